// File: rtl/bankgroup_rd_collector_if.sv
// Handshake bundle between the bankgroup read path, the PE consumer and bankgroup_rd_collector.
// Statistics signals exist only when RD_COLLECT_STAT_EN is defined.
interface bankgroup_rd_collector_if #(
  parameter int DATA_W = 32
);
  logic              req_valid_i;
  logic              flush_i;
  logic [DATA_W:0]   dout_bus_i;
  logic              issue_ready_o;
  logic              rd_valid_o;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_ready_i;
  logic              err_overrun_o;
  logic              err_spurious_o;
`ifdef RD_COLLECT_STAT_EN
  logic [31:0]       stat_rd_cnt_o;
  logic [31:0]       stat_stall_cnt_o;

  modport master (
    output req_valid_i, flush_i, dout_bus_i, rd_ready_i,
    input  issue_ready_o, rd_valid_o, rd_data_o, err_overrun_o, err_spurious_o,
    input  stat_rd_cnt_o, stat_stall_cnt_o
  );

  modport slave (
    input  req_valid_i, flush_i, dout_bus_i, rd_ready_i,
    output issue_ready_o, rd_valid_o, rd_data_o, err_overrun_o, err_spurious_o,
    output stat_rd_cnt_o, stat_stall_cnt_o
  );
`else
  modport master (
    output req_valid_i, flush_i, dout_bus_i, rd_ready_i,
    input  issue_ready_o, rd_valid_o, rd_data_o, err_overrun_o, err_spurious_o
  );

  modport slave (
    input  req_valid_i, flush_i, dout_bus_i, rd_ready_i,
    output issue_ready_o, rd_valid_o, rd_data_o, err_overrun_o, err_spurious_o
  );
`endif
endinterface

// File: rtl/bankgroup_rd_collector.sv
// Collects bankgroup read responses in order into a small FIFO with issue credit and error flags.
// Optional pop/stall statistics counters are enabled by defining RD_COLLECT_STAT_EN.
module bankgroup_rd_collector #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input logic                          clk,
  input logic                          rst,
  bankgroup_rd_collector_if.slave      bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  os_q, occ_q;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              err_overrun_q, err_spurious_q;

  logic              resp_v;
  logic [DATA_W-1:0] resp_data;
  logic [CNT_W:0]    credit_sum;
  logic              issue_ready;
  logic              req_fire, resp_ok, pop, push, full;
  logic [CNT_W-1:0]  os_next, occ_next, occ_after_pop;
  logic [PTR_W-1:0]  rd_ptr_next;

  assign resp_v      = bus.dout_bus_i[DATA_W];
  assign resp_data   = bus.dout_bus_i[DATA_W-1:0];
  // Credit is decoded from registered counters only, so no input reaches issue_ready_o.
  assign credit_sum  = {1'b0, os_q} + {1'b0, occ_q};
  assign issue_ready = credit_sum < (CNT_W+1)'(DEPTH);

  assign req_fire = bus.req_valid_i & issue_ready;
  assign resp_ok  = resp_v & ((os_q != '0) | req_fire);
  assign pop      = rd_valid_q & bus.rd_ready_i;
  assign full     = occ_q == CNT_W'(DEPTH);
  assign push     = resp_ok & (~full | pop);

  assign occ_after_pop = occ_q - CNT_W'(pop);
  assign rd_ptr_next   = rd_ptr_q + PTR_W'(pop);

  always_comb begin
    os_next = os_q;
    if (req_fire & ~resp_ok)      os_next = os_q + 1'b1;
    else if (resp_ok & ~req_fire) os_next = os_q - 1'b1;
    occ_next = occ_after_pop + CNT_W'(push);
  end

  // NOTE: storage carries no reset; pointers and occupancy alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push & ~bus.flush_i & ~rst) mem[wr_ptr_q] <= resp_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      os_q           <= '0;
      occ_q          <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      err_overrun_q  <= 1'b0;
      err_spurious_q <= 1'b0;
    end else if (bus.flush_i) begin
      os_q       <= '0;
      occ_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      os_q       <= os_next;
      occ_q      <= occ_next;
      rd_ptr_q   <= rd_ptr_next;
      wr_ptr_q   <= wr_ptr_q + PTR_W'(push);
      rd_valid_q <= occ_next != '0;
      // Head register: an empty-after-pop FIFO takes the incoming word, otherwise the next stored entry.
      if (occ_after_pop == '0) begin
        if (push) rd_data_q <= resp_data;
      end else begin
        rd_data_q <= mem[rd_ptr_next];
      end
      if ((bus.req_valid_i & ~issue_ready) | (resp_ok & full & ~pop)) err_overrun_q <= 1'b1;
      if (resp_v & ~resp_ok) err_spurious_q <= 1'b1;
    end
  end

  assign bus.issue_ready_o  = issue_ready;
  assign bus.rd_valid_o     = rd_valid_q;
  assign bus.rd_data_o      = rd_data_q;
  assign bus.err_overrun_o  = err_overrun_q;
  assign bus.err_spurious_o = err_spurious_q;

`ifdef RD_COLLECT_STAT_EN
  logic [31:0] stat_rd_cnt_q, stat_stall_cnt_q;

  // Statistics survive flush; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_cnt_q    <= '0;
      stat_stall_cnt_q <= '0;
    end else begin
      if (pop && stat_rd_cnt_q != 32'hffff_ffff) stat_rd_cnt_q <= stat_rd_cnt_q + 1'b1;
      if (rd_valid_q && !bus.rd_ready_i && stat_stall_cnt_q != 32'hffff_ffff)
        stat_stall_cnt_q <= stat_stall_cnt_q + 1'b1;
    end
  end

  assign bus.stat_rd_cnt_o    = stat_rd_cnt_q;
  assign bus.stat_stall_cnt_o = stat_stall_cnt_q;
`endif
endmodule
